hazard_forward_unit: RTL
========================

Name: hazard_forward_unit

Overview:
- Produces the 3-bit forwarding selects consumed by the EX-stage operand muxes.
- Detects load-use hazards and issues a one-cycle pipeline stall.
- Internally tracks the destination register, reg-write and mem-read state of the instructions in EX/MEM and MEM/WB, plus the rs/rt of the instruction in ID/EX.
- Sits beside the ID/EX, EX/MEM and MEM/WB latches and advances with them under the debug step/enable.

Parameters:
BITS_REGS, 5, register index width
BITS_CORTOCIRCUITO, 3, forwarding select width
BITS_COUNT, 32, stall counter width

Ports:
i_clk  input  1  clock, rising edge
i_reset  input  1  synchronous active-high reset
i_enable  input  1  pipeline advance (debug step); 0 = every register holds
i_flush  input  1  branch/jump taken; squash the instruction in ID
i_id_valid  input  1  ID holds a real instruction
i_id_rs  input  BITS_REGS  rs of the ID instruction
i_id_rt  input  BITS_REGS  rt of the ID instruction
i_ex_rd  input  BITS_REGS  destination chosen by the EX rt/rd mux
i_ex_reg_write  input  1  EX instruction writes the register file
i_ex_mem_read  input  1  EX instruction is a load
o_corto_register_A  output  BITS_CORTOCIRCUITO  forwarding select for operand A in EX
o_corto_register_B  output  BITS_CORTOCIRCUITO  forwarding select for operand B in EX
o_stall  output  1  hold PC and IF/ID; load bubble into ID/EX
o_stall_count  output  BITS_COUNT  number of stall cycles since reset

Behaviour:
- Select encoding:
  - 3'b000 = ID/EX register-file value.
  - 3'b001 = EX/MEM result.
  - 3'b010 = MEM/WB write-back data.
  - Other codes are never driven.
- Internal state:
  - idex_rs, idex_rt, idex_valid.
  - exmem_rd, exmem_wr.
  - memwb_rd, memwb_wr.
  - FSM state.
  - stall counter.
- Reset (i_reset=1 at a clock edge): all internal state goes to 0 and the FSM goes to RUN. Outputs then read A=B=000, o_stall=0, o_stall_count=0. Reset overrides i_enable and i_flush, including mid-stall.
- Advance on each edge with i_enable=1 and no reset:
  - memwb_{rd,wr} <= exmem_{rd,wr}.
  - exmem_{rd,wr} <= {i_ex_rd, i_ex_reg_write}.
  - If (o_stall or i_flush or !i_id_valid): idex_valid <= 0 and idex_rs/rt <= 0. Otherwise idex_{rs,rt,valid} <= {i_id_rs, i_id_rt, 1}.
- Hold: with i_enable=0 every register holds, outputs stay stable, and the counter does not increment.
- Forwarding is combinational from registered state only; there is no input-to-select path. For operand X (rs for A, rt for B):
  - If idex_valid & exmem_wr & exmem_rd!=0 & exmem_rd==X, select 001.
  - Else if idex_valid & memwb_wr & memwb_rd!=0 & memwb_rd==X, select 010.
  - Else select 000.
  - EX/MEM has priority over MEM/WB when both match.
  - Register 0 is never forwarded.
- Load-use detect, combinational: hz = i_id_valid & i_ex_mem_read & i_ex_reg_write & i_ex_rd!=0 & (i_ex_rd==i_id_rs | i_ex_rd==i_id_rt).
- FSM:
  - RUN: o_stall = hz & !i_flush. If i_enable and o_stall, go to STALL.
  - STALL: o_stall=0; this guarantees at most one bubble per load. On i_enable, go to RUN. With i_enable=0, stay in STALL.
- Flush and hazard in the same cycle: flush wins, o_stall=0, and the ID instruction is squashed.
- Counter: increments by 1 on each advancing edge where o_stall=1. Wraps from all-ones to 0.
- Latency:
  - A producer's result is forwarded as 001 in the cycle after it leaves EX.
  - It is forwarded as 010 in the cycle after that.

Test Plan:
- Reset then step: add r3 in EX (i_ex_rd=3, wr=1), ID reads rs=3. Next cycle A=001, B=000. One more step with no new writer: A=010. Step again: A=000.
- Double hit: EX/MEM rd=5 and MEM/WB rd=5, both writing; idex rs=rt=5 -> A=B=001 (EX/MEM priority).
- r0 writer: exmem_rd=0, wr=1, idex rs=0 -> A=000. Also i_ex_rd=0 with mem_read=1 -> o_stall=0.
- Load-use: i_ex_mem_read=1, wr=1, i_ex_rd=7, i_id_rt=7, valid=1 -> o_stall=1 for exactly one enabled cycle, o_stall_count 0->1. Following cycle o_stall=0 with the same inputs (STALL state), and idex_valid=0 (bubble, A=B=000).
- Same load-use with i_flush=1 -> o_stall=0, counter unchanged, next idex_valid=0. Repeat with i_enable=0 for 3 cycles -> outputs and counter frozen.
- Reset asserted while in STALL -> next cycle FSM RUN, selects 000, o_stall_count=0, o_stall follows hz immediately.

Source files
------------

// File: rtl/hazard_forward_unit.sv
// Forwarding-select and load-use stall unit for the EX stage.
// Tracks rs/rt in ID/EX and writers in EX/MEM and MEM/WB; stalls at most one cycle per load.

module hfu_fwd_sel #(
  parameter int BITS_REGS          = 5,
  parameter int BITS_CORTOCIRCUITO = 3
) (
  input  logic                          idex_valid_i,
  input  logic [BITS_REGS-1:0]          src_i,
  input  logic [BITS_REGS-1:0]          exmem_rd_i,
  input  logic                          exmem_wr_i,
  input  logic [BITS_REGS-1:0]          memwb_rd_i,
  input  logic                          memwb_wr_i,
  output logic [BITS_CORTOCIRCUITO-1:0] sel_o
);
  localparam logic [BITS_CORTOCIRCUITO-1:0] SEL_RF    = '0;
  localparam logic [BITS_CORTOCIRCUITO-1:0] SEL_EXMEM = BITS_CORTOCIRCUITO'(1);
  localparam logic [BITS_CORTOCIRCUITO-1:0] SEL_MEMWB = BITS_CORTOCIRCUITO'(2);

  logic hit_exmem, hit_memwb;

  // r0 is hardwired zero, so a write to it must never be forwarded.
  assign hit_exmem = idex_valid_i & exmem_wr_i & (exmem_rd_i != '0) & (exmem_rd_i == src_i);
  assign hit_memwb = idex_valid_i & memwb_wr_i & (memwb_rd_i != '0) & (memwb_rd_i == src_i);

  always_comb begin
    sel_o = SEL_RF;
    if (hit_exmem)      sel_o = SEL_EXMEM;
    else if (hit_memwb) sel_o = SEL_MEMWB;
  end
endmodule

module hazard_forward_unit #(
  parameter int BITS_REGS          = 5,
  parameter int BITS_CORTOCIRCUITO = 3,
  parameter int BITS_COUNT         = 32
) (
  input  logic                          i_clk,
  input  logic                          i_reset,
  input  logic                          i_enable,
  input  logic                          i_flush,
  input  logic                          i_id_valid,
  input  logic [BITS_REGS-1:0]          i_id_rs,
  input  logic [BITS_REGS-1:0]          i_id_rt,
  input  logic [BITS_REGS-1:0]          i_ex_rd,
  input  logic                          i_ex_reg_write,
  input  logic                          i_ex_mem_read,
  output logic [BITS_CORTOCIRCUITO-1:0] o_corto_register_A,
  output logic [BITS_CORTOCIRCUITO-1:0] o_corto_register_B,
  output logic                          o_stall,
  output logic [BITS_COUNT-1:0]         o_stall_count
);
  localparam int NUM_OPS = 2;

  typedef enum logic [0:0] {RUN = 1'b0, STALL = 1'b1} state_t;

  typedef struct packed {
    logic [BITS_REGS-1:0] rd;
    logic                 wr;
  } writer_t;

  typedef struct packed {
    logic [BITS_REGS-1:0] rs;
    logic [BITS_REGS-1:0] rt;
    logic                 valid;
  } idex_t;

  state_t                 state_q, state_d;
  idex_t                  idex_q, idex_d;
  writer_t                exmem_q, exmem_d;
  writer_t                memwb_q, memwb_d;
  logic [BITS_COUNT-1:0]  cnt_q, cnt_d;
  logic                   hz;

  logic [NUM_OPS-1:0][BITS_REGS-1:0]          op_src;
  logic [NUM_OPS-1:0][BITS_CORTOCIRCUITO-1:0] op_sel;

  assign hz = i_id_valid & i_ex_mem_read & i_ex_reg_write & (i_ex_rd != '0) &
              ((i_ex_rd == i_id_rs) | (i_ex_rd == i_id_rt));

  // One bubble per load: the STALL state masks the hazard the cycle after it fired.
  assign o_stall = (state_q == RUN) & hz & ~i_flush;

  always_comb begin
    state_d = state_q;
    idex_d  = idex_q;
    exmem_d = exmem_q;
    memwb_d = memwb_q;
    cnt_d   = cnt_q;
    if (i_enable) begin
      memwb_d = exmem_q;
      exmem_d = '{rd: i_ex_rd, wr: i_ex_reg_write};
      if (o_stall | i_flush | ~i_id_valid) idex_d = '0;
      else idex_d = '{rs: i_id_rs, rt: i_id_rt, valid: 1'b1};
      if (o_stall) cnt_d = cnt_q + BITS_COUNT'(1);
      case (state_q)
        RUN:     state_d = o_stall ? STALL : RUN;
        STALL:   state_d = RUN;
        default: state_d = RUN;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q <= RUN;
      idex_q  <= '0;
      exmem_q <= '0;
      memwb_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      idex_q  <= idex_d;
      exmem_q <= exmem_d;
      memwb_q <= memwb_d;
      cnt_q   <= cnt_d;
    end
  end

  assign op_src[0] = idex_q.rs;
  assign op_src[1] = idex_q.rt;

  for (genvar g = 0; g < NUM_OPS; g++) begin : g_op
    hfu_fwd_sel #(
      .BITS_REGS          (BITS_REGS),
      .BITS_CORTOCIRCUITO (BITS_CORTOCIRCUITO)
    ) u_sel (
      .idex_valid_i (idex_q.valid),
      .src_i        (op_src[g]),
      .exmem_rd_i   (exmem_q.rd),
      .exmem_wr_i   (exmem_q.wr),
      .memwb_rd_i   (memwb_q.rd),
      .memwb_wr_i   (memwb_q.wr),
      .sel_o        (op_sel[g])
    );
  end

  assign o_corto_register_A = op_sel[0];
  assign o_corto_register_B = op_sel[1];
  assign o_stall_count      = cnt_q;
endmodule
